uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 146 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// single-entry output register with valid/ready handshake and sticky overrun.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge on rxs
//   START     | half-bit wait, then confirm start bit is still low
//   DATA      | sampling DATA_W data bits, LSB first
//   PARITY    | sampling the parity bit
//   STOP      | sampling STOP_BITS stop bits
module uart_rx_cfg #(
    parameter int FCLK      = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk50m,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              rx_idle
);

    localparam int BP  = FCLK / BAUD;
    localparam int TW  = $clog2(BP);
    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0]  HALF_LOAD = TW'(BP / 2 - 1);
    localparam logic [TW-1:0]  FULL_LOAD = TW'(BP - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state, state_nx;

    logic              rx_s1, rxs, rxs_prev;
    logic [TW-1:0]     timer;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              perr_acc, ferr_acc;
    logic              fall, tick, done, accept;

    assign fall    = rxs_prev && !rxs;
    assign tick    = (state != ST_IDLE) && (timer == '0);
    assign done    = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    assign accept  = rx_valid && rx_ready;
    assign rx_idle = (state == ST_IDLE);

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_s1    <= rx;
            rxs      <= rx_s1;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (fall) state_nx = ST_START;
            ST_START:  if (tick) state_nx = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && bit_cnt == LAST_BIT)
                           state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_nx = ST_STOP;
            ST_STOP:   if (done) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Bit timer and per-frame accumulation
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            if (state == ST_IDLE) timer <= fall ? HALF_LOAD : '0;
            else                  timer <= tick ? FULL_LOAD : timer - 1'b1;

            if (tick) begin
                case (state)
                    ST_START: begin
                        bit_cnt  <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                    ST_DATA: begin
                        shreg   <= {rxs, shreg[DATA_W-1:1]};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                    ST_PARITY: perr_acc <= (PARITY == 1) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
                    ST_STOP: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (!rxs) ferr_acc <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register: a full slot that is not being drained drops the new frame
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (done && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                parity_err <= perr_acc;
                frame_err  <= ferr_acc | ~rxs;
                rx_valid   <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end

            if (done && rx_valid && !rx_ready) overrun_err <= 1'b1;
            else if (accept)                   overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at BP = 16,
// expected words queued per instance and checked by a monitor on each accept.
module tb_uart_rx_cfg;

    localparam int PAR [3] = '{0, 2, 0};
    localparam int STP [3] = '{1, 1, 2};

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       o;
    } exp_t;

    logic       clk50m = 1'b0;
    logic       rst    = 1'b1;
    logic       rx_v   [3];
    logic       rdy    [3];
    logic [7:0] dat    [3];
    logic       vld    [3];
    logic       perr   [3];
    logic       ferr   [3];
    logic       oerr   [3];
    logic       idl    [3];

    exp_t exp_q [3][$];
    int   vcount [3];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk50m = ~clk50m;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_cfg #(
            .FCLK(16), .BAUD(1), .DATA_W(8), .PARITY(PAR[g]), .STOP_BITS(STP[g])
        ) dut (
            .clk50m     (clk50m),
            .rst        (rst),
            .rx         (rx_v[g]),
            .rx_data    (dat[g]),
            .rx_valid   (vld[g]),
            .rx_ready   (rdy[g]),
            .parity_err (perr[g]),
            .frame_err  (ferr[g]),
            .overrun_err(oerr[g]),
            .rx_idle    (idl[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    // bits[0] goes on the line first; each bit lasts one bit period
    task automatic send(input int k, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_v[k] = bits[i];
            idle(16);
        end
        rx_v[k] = 1'b1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e.d = d; e.p = p; e.f = f; e.o = o;
        exp_q[k].push_back(e);
    endtask

    initial begin
        int   vc0;
        logic [7:0] b;
        for (int k = 0; k < 3; k++) begin
            rx_v[k] = 1'b1; rdy[k] = 1'b1; vcount[k] = 0;
        end

        fork
            forever begin
                @(negedge clk50m);
                for (int k = 0; k < 3; k++) begin
                    if (vld[k]) begin
                        vcount[k]++;
                        if (rdy[k]) begin
                            if (exp_q[k].size() == 0) begin
                                check("unexpected_word", {24'd0, dat[k]}, 32'hFFFF_FFFF);
                            end else begin
                                exp_t e;
                                e = exp_q[k].pop_front();
                                check("rx_data",     {24'd0, dat[k]}, {24'd0, e.d});
                                check("parity_err",  {31'd0, perr[k]}, {31'd0, e.p});
                                check("frame_err",   {31'd0, ferr[k]}, {31'd0, e.f});
                                check("overrun_err", {31'd0, oerr[k]}, {31'd0, e.o});
                            end
                        end
                    end
                end
            end
        join_none

        idle(3);
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", {31'd0, vld[k]}, 32'd0);
            check("rst_idle",  {31'd0, idl[k]}, 32'd1);
            check("rst_data",  {24'd0, dat[k]}, 32'd0);
        end
        rst = 1'b0;
        idle(20);

        // 8N1 0xA5, ready held high: exactly one valid cycle
        vcount[0] = 0;
        push(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        idle(16);
        check("a5_valid_cycles", vcount[0], 32'd1);
        check("a5_idle_after",   {31'd0, idl[0]}, 32'd1);

        // 8E1 0x03: parity bit 1 makes three ones (bad), parity bit 0 is good
        push(1, 8'h03, 1'b1, 1'b0, 1'b0);
        send(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        idle(16);
        push(1, 8'h03, 1'b0, 1'b0, 1'b0);
        send(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        idle(16);

        // 8N2 0x55 with second stop low, then a clean 0xC3
        push(2, 8'h55, 1'b0, 1'b1, 1'b0);
        send(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
        idle(16);
        push(2, 8'hC3, 1'b0, 1'b0, 1'b0);
        send(2, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11);
        idle(16);

        // Back-to-back 0x11, 0x22 with ready low: second frame is dropped
        rdy[0] = 1'b0;
        push(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        idle(16);
        check("ovr_valid_held", {31'd0, vld[0]}, 32'd1);
        check("ovr_data_kept",  {24'd0, dat[0]}, 32'h11);
        check("ovr_flag_set",   {31'd0, oerr[0]}, 32'd1);
        rdy[0] = 1'b1;
        idle(1);
        rdy[0] = 1'b0;
        check("ovr_valid_clr", {31'd0, vld[0]}, 32'd0);
        check("ovr_flag_clr",  {31'd0, oerr[0]}, 32'd0);
        check("ovr_data_hold", {24'd0, dat[0]}, 32'h11);
        idle(4);
        rdy[0] = 1'b1;

        // 4-clock low glitch: START entered, then false start back to IDLE
        vc0 = vcount[0];
        rx_v[0] = 1'b0;
        idle(4);
        rx_v[0] = 1'b1;
        check("glitch_in_start", {31'd0, idl[0]}, 32'd0);
        idle(30);
        check("glitch_back_idle", {31'd0, idl[0]}, 32'd1);
        check("glitch_no_valid",  vcount[0] - vc0, 32'd0);

        // Reset in the middle of bit 3 of 0x7E
        b = 8'h7E;
        rx_v[0] = 1'b0; idle(16);
        for (int i = 0; i < 3; i++) begin rx_v[0] = b[i]; idle(16); end
        rx_v[0] = b[3]; idle(8);
        #2 rst = 1'b1;
        rx_v[0] = 1'b1;
        #1;
        check("midrst_idle",  {31'd0, idl[0]}, 32'd1);
        check("midrst_valid", {31'd0, vld[0]}, 32'd0);
        check("midrst_data",  {24'd0, dat[0]}, 32'd0);
        check("midrst_oerr",  {31'd0, oerr[0]}, 32'd0);
        check("midrst_ferr",  {31'd0, ferr[0]}, 32'd0);
        idle(3);
        rst = 1'b0;
        vc0 = vcount[0];
        idle(40);
        check("postrst_no_valid", vcount[0] - vc0, 32'd0);
        push(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        send(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10);

        idle(40);
        for (int k = 0; k < 3; k++)
            check("queue_drained", exp_q[k].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
